alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ACTION_LEN, default 64, action word width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, container width.
REQ-003 SHALL have parameter NUM_CONT, default 8, containers per PHV; PHV width = NUM_CONT*DATA_WIDTH (256). Container i = phv[32*i+31:32*i].
REQ-004 SHALL have parameter TIMEOUT, default 255, max WAIT cycles.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 phv_in  in  256  input PHV.
REQ-008 phv_in_valid  in  1 / phv_in_ready  out  1  upstream handshake.
REQ-009 action_in  in  64  action word, sampled with phv_in.
REQ-010 alu_action  out  64 / alu_action_valid  out  1 / alu_ready  in  1  ALU issue handshake.
REQ-011 alu_op1, alu_op2, alu_op3, alu_op4  out  32 each  ALU operands.
REQ-012 alu_result  in  32 / alu_result_valid  in  1 / alu_result_ready  out  1  ALU result handshake.
REQ-013 phv_out  out  256 / phv_out_valid  out  1 / phv_out_ready  in  1  downstream handshake.
REQ-014 timeout_err  out  1  sticky error flag; issue_cnt  out  16  count of ALU issues.

Function
REQ-015 Action fields: [63:56] opcode, [55:53] s1, [52:50] s2, [49:47] s3, [46:44] dst, [43] wb_en, [36:32] addr5, [31:0] imm32; others ignored.
REQ-016 alu_action SHALL equal the latched action word; alu_op1 = container[s1]; alu_op3 = container[s3].
REQ-017 alu_op2 SHALL be {27'b0,addr5} for opcodes 0x07,0x08,0x0B,0x0C; imm32 for 0x09,0x0A,0x0E; else container[s2].
REQ-018 alu_op4 SHALL be imm32 for opcode 0x0C, else 0.
REQ-019 Opcode 0x00 is NOP: no ALU issue, PHV forwarded unmodified.
REQ-020 FSM states IDLE, ISSUE, WAIT, OUT; reset state IDLE.
REQ-021 IDLE: phv_in_ready=1; on phv_in_valid latch phv_in and action_in; -> OUT if NOP else -> ISSUE.
REQ-022 ISSUE: phv_in_ready=0; alu_action_valid=1 only in a cycle where alu_ready=1; that cycle is the accept, -> WAIT, issue_cnt +1 (wraps at 0xFFFF); alu_action_valid SHALL be a single-cycle pulse per action.
REQ-023 ISSUE with alu_ready=0: alu_action_valid=0, stay, operands held stable.
REQ-024 WAIT: alu_result_ready=1 every cycle; on alu_result_valid, if wb_en write alu_result into container[dst] of latched PHV, -> OUT; wb_en=0 leaves PHV unchanged.
REQ-025 WAIT watchdog: 8-bit counter cleared on WAIT entry, increments each WAIT cycle without result; at TIMEOUT set timeout_err, -> OUT with PHV unmodified.
REQ-026 Result arriving in same cycle counter reaches TIMEOUT SHALL take priority (write, no error).
REQ-027 OUT: phv_out_valid=1, phv_out stable until phv_out_ready=1, then -> IDLE; phv_in_ready=0 in OUT (no overlap).
REQ-028 alu_result_valid outside WAIT SHALL be ignored.
REQ-029 Latency: NOP accepted at cycle T -> phv_out_valid at T+1; ALU op -> phv_out_valid one cycle after alu_result_valid sampled.

Reset
REQ-030 On rst_n=0: state IDLE, phv_in_ready=0 during reset then 1 after, alu_action_valid=0, alu_result_ready=0, phv_out_valid=0, phv_out=0, alu_action and operands 0, timeout_err=0, issue_cnt=0, watchdog=0.
REQ-031 Reset mid-operation SHALL abandon the in-flight action with no phv_out_valid pulse; late alu_result_valid after reset ignored.

Verification
REQ-032 add: container1=5, container2=7, action opcode 0x01 s1=1 s2=2 dst=4 wb_en=1, ALU model returns 12 -> phv_out container4=12, others unchanged, issue_cnt=1.
REQ-033 addi 0x09 imm32=0x10, s1=0 (=3) -> alu_op2=0x10, alu_op1=3; store 0x08 addr5=9 -> alu_op2=9.
REQ-034 NOP action, phv_out_ready=1 -> phv_out_valid cycle after accept, phv_out==phv_in, alu_action_valid never asserted.
REQ-035 alu_ready held 0 for 10 cycles in ISSUE -> no alu_action_valid; on alu_ready=1 exactly one 1-cycle pulse.
REQ-036 ALU never responds -> after 255 WAIT cycles timeout_err=1, phv_out equals latched phv_in; flag stays 1 through later actions until reset.
REQ-037 phv_out_ready held 0 for 5 cycles in OUT -> phv_out stable, phv_in_ready=0; rst_n pulse in WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: latches a PHV plus action word, issues operands to an external ALU,
// waits (with a watchdog) for the result, optionally writes it back, then forwards the PHV downstream.
module alu_issue_ctrl #(
  parameter int ACTION_LEN = 64,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [NUM_CONT*DATA_WIDTH-1:0] i_phv_in,
  input  logic                           i_phv_in_valid,
  output logic                           o_phv_in_ready,
  input  logic [ACTION_LEN-1:0]          i_action_in,

  output logic [ACTION_LEN-1:0]          o_alu_action,
  output logic                           o_alu_action_valid,
  input  logic                           i_alu_ready,
  output logic [DATA_WIDTH-1:0]          o_alu_op1,
  output logic [DATA_WIDTH-1:0]          o_alu_op2,
  output logic [DATA_WIDTH-1:0]          o_alu_op3,
  output logic [DATA_WIDTH-1:0]          o_alu_op4,

  input  logic [DATA_WIDTH-1:0]          i_alu_result,
  input  logic                           i_alu_result_valid,
  output logic                           o_alu_result_ready,

  output logic [NUM_CONT*DATA_WIDTH-1:0] o_phv_out,
  output logic                           o_phv_out_valid,
  input  logic                           i_phv_out_ready,

  output logic                           o_timeout_err,
  output logic [15:0]                    o_issue_cnt
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                         r_state;
  state_t                         w_nextState;

  logic [NUM_CONT*DATA_WIDTH-1:0] r_phv;
  logic [ACTION_LEN-1:0]          r_action;
  logic [7:0]                     r_wdog;
  logic                           r_timeoutErr;
  logic [15:0]                    r_issueCnt;

  logic                           w_accept;
  logic                           w_issue;
  logic                           w_resultTake;
  logic                           w_timeout;

  logic [7:0]                     w_inOpcode;
  logic [7:0]                     w_opcode;
  logic [2:0]                     w_s1;
  logic [2:0]                     w_s2;
  logic [2:0]                     w_s3;
  logic [2:0]                     w_dst;
  logic                           w_wbEn;
  logic [4:0]                     w_addr5;
  logic [DATA_WIDTH-1:0]          w_imm;
  logic [DATA_WIDTH-1:0]          w_cont [NUM_CONT];

  assign w_inOpcode = i_action_in[63:56];
  assign w_opcode   = r_action[63:56];
  assign w_s1       = r_action[55:53];
  assign w_s2       = r_action[52:50];
  assign w_s3       = r_action[49:47];
  assign w_dst      = r_action[46:44];
  assign w_wbEn     = r_action[43];
  assign w_addr5    = r_action[36:32];
  assign w_imm      = DATA_WIDTH'(r_action[31:0]);

  always_comb begin
    for (int i = 0; i < NUM_CONT; i++) begin
      w_cont[i] = r_phv[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake outputs are forced low while rst_n is held so nothing leaks out during reset.
  always_comb begin
    w_nextState        = r_state;
    o_phv_in_ready     = 1'b0;
    o_alu_action_valid = 1'b0;
    o_alu_result_ready = 1'b0;
    o_phv_out_valid    = 1'b0;
    w_accept           = 1'b0;
    w_issue            = 1'b0;
    w_resultTake       = 1'b0;
    w_timeout          = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          o_phv_in_ready = 1'b1;
          if (i_phv_in_valid) begin
            w_accept    = 1'b1;
            w_nextState = (w_inOpcode == 8'h00) ? S_OUT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_alu_ready) begin
            o_alu_action_valid = 1'b1;
            w_issue            = 1'b1;
            w_nextState        = S_WAIT;
          end
        end
        S_WAIT: begin
          o_alu_result_ready = 1'b1;
          if (i_alu_result_valid) begin
            w_resultTake = 1'b1;
            w_nextState  = S_OUT;
          end else if (r_wdog == TIMEOUT_LAST) begin
            w_timeout   = 1'b1;
            w_nextState = S_OUT;
          end
        end
        S_OUT: begin
          o_phv_out_valid = 1'b1;
          if (i_phv_out_ready) begin
            w_nextState = S_IDLE;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phv    <= '0;
      r_action <= '0;
    end else if (w_accept) begin
      r_phv    <= i_phv_in;
      r_action <= i_action_in;
    end else if (w_resultTake && w_wbEn) begin
      for (int i = 0; i < NUM_CONT; i++) begin
        if (w_dst == 3'(i)) begin
          r_phv[i*DATA_WIDTH +: DATA_WIDTH] <= i_alu_result;
        end
      end
    end
  end

  // Watchdog restarts on every issue; a result in the final cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (w_issue) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT && !i_alu_result_valid && !w_timeout) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeoutErr <= 1'b0;
      r_issueCnt   <= '0;
    end else begin
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
      end
      if (w_issue) begin
        r_issueCnt <= r_issueCnt + 16'd1;
      end
    end
  end

  always_comb begin
    o_alu_op1 = w_cont[w_s1];
    o_alu_op3 = w_cont[w_s3];
    case (w_opcode)
      8'h07, 8'h08, 8'h0B, 8'h0C: o_alu_op2 = {{(DATA_WIDTH-5){1'b0}}, w_addr5};
      8'h09, 8'h0A, 8'h0E:        o_alu_op2 = w_imm;
      default:                    o_alu_op2 = w_cont[w_s2];
    endcase
    o_alu_op4 = (w_opcode == 8'h0C) ? w_imm : '0;
  end

  assign o_alu_action  = r_action;
  assign o_phv_out     = r_phv;
  assign o_timeout_err = r_timeoutErr;
  assign o_issue_cnt   = r_issueCnt;

endmodule
